proj_read_scheduler: RTL and testbench
======================================

PROJ_READ_SCHEDULER -- requirements
Module: proj_read_scheduler

Interface
REQ-001 Parameter MAX_READS, default 7'd100: maximum reads issued per BX, range 1..127.
REQ-002 Parameter MEM_LATENCY, default 2: cycles from registered read address to valid memory data, range 1..4.
REQ-003 clk  input  1  the single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle BX boundary pulse.
REQ-006 BX  input  3  BX number of the BX beginning with start.
REQ-007 number_in_proj1in / number_in_proj2in / number_in_proj3in  input  6 each  entries currently held in source memory 0/1/2; live value, may grow during a BX.
REQ-008 read_add_proj1in / read_add_proj2in / read_add_proj3in  output  6 each  registered read address to source memory 0/1/2.
REQ-009 sel  output  2  source (0..2) of the data word on the memory outputs this cycle.
REQ-010 index  output  6  address of that data word.
REQ-011 valid_data  output  1  memory data, sel and index valid this cycle.
REQ-012 bx_out  output  3  BX tag of the valid word.
REQ-013 done  output  1  one-cycle pulse: previous BX fully drained.
REQ-014 done_bx  output  3  BX that completed, valid with done.
REQ-015 busy  output  1  high in RUN state.
REQ-016 overflow  output  1  sticky per BX: read budget exhausted.

Function
REQ-017 State machine SHALL have states IDLE, RUN, STALL.
- IDLE: no reads; start -> RUN.
- RUN: arbitrate and issue reads; issued count = MAX_READS -> STALL; start -> RUN (new BX).
- STALL: no reads; start -> RUN.
REQ-018 On start (any state) the block SHALL latch BX, clear all three per-source counters and the issued count to 0, and clear overflow; start has priority over a same-cycle budget exhaustion.
REQ-019 Source k is pending when its counter < number_in of source k, compared unsigned with 6-bit operands.
REQ-020 In RUN, including the start cycle, at most one pending source is granted per cycle, round-robin: search order (last+1)%3, (last+2)%3, last; last = most recently granted source.
REQ-021 The granted source's read_add SHALL be set to its counter value, and its counter and the issued count SHALL increment.
- Non-granted read_add outputs hold their value.
- Counters never wrap: a counter at 63 is not pending.
REQ-022 No pending source in RUN: no read, stay in RUN, no timeout.
REQ-023 A read issued with registered read_add at cycle t SHALL produce valid_data=1 at cycle t+MEM_LATENCY.
- Same cycle: sel = source, index = address, bx_out = BX latched at issue.
- Implemented as a MEM_LATENCY-deep shift pipeline of {valid, sel, index, bx}.
REQ-024 valid_data SHALL be 0 in every cycle with no matching issue; sel, index and bx_out hold their last value when not valid.
REQ-025 Issued count reaching MAX_READS: overflow=1 in the following cycle, held until next start; state -> STALL.
REQ-026 done SHALL pulse exactly MEM_LATENCY cycles after each start that was not the first start since reset, with done_bx = BX of the previous run.
- In-flight reads of the previous BX still emerge with their old bx_out tag.
REQ-027 busy = 1 iff state is RUN.

Reset
REQ-028 While reset=0 at a clock edge:
- state -> IDLE, last -> 2, so source 0 is granted first.
- All counters, read_add outputs, sel, index, bx_out and done_bx -> 0.
- valid_data, done, busy and overflow -> 0; the pipeline is flushed.
- start is ignored.
REQ-029 Reset mid-RUN SHALL discard all in-flight reads: no valid_data and no done after reset release until a new start.

Verification
REQ-030 Scenario 1. Stimulus: reset, start with BX=3, numbers 2,1,0, MEM_LATENCY=2. Required: reads issued in order src0@0, src1@0, src0@1; valid_data high for 3 consecutive cycles, 2 cycles after each issue; bx_out=3.
REQ-031 Scenario 2. Stimulus: start with numbers 0,0,0. Required: no valid_data, busy=1; number_in_proj2in raised to 1 -> exactly one read, src1@0.
REQ-032 Scenario 3. Stimulus: MAX_READS=4, numbers 3,3,3. Required: reads src0@0, src1@0, src2@0, src0@1; then overflow=1, busy=0, no further reads until the next start.
REQ-033 Scenario 4. Stimulus: start BX=5, then start BX=6 with 2 reads in flight. Required: the 2 in-flight words emerge with bx_out=5; done=1 with done_bx=5, MEM_LATENCY cycles after the second start; new reads are tagged bx_out=6.
REQ-034 Scenario 5. Stimulus: reset=0 asserted during RUN with reads in flight. Required: next cycle all outputs 0 and valid_data stays 0; first start after release produces no done.
REQ-035 Scenario 6. Stimulus: start and budget exhaustion in the same cycle. Required: state RUN, overflow=0, counters cleared.

Source files
------------

// File: rtl/proj_read_scheduler_if.sv
// Bundle between proj_read_scheduler and its environment: BX control, source fill levels,
// per-source read addresses and the tagged memory-data qualifiers.
interface proj_read_scheduler_if;
    logic       start;
    logic [2:0] BX;
    logic [5:0] number_in_proj1in;
    logic [5:0] number_in_proj2in;
    logic [5:0] number_in_proj3in;
    logic [5:0] read_add_proj1in;
    logic [5:0] read_add_proj2in;
    logic [5:0] read_add_proj3in;
    logic [1:0] sel;
    logic [5:0] index;
    logic       valid_data;
    logic [2:0] bx_out;
    logic       done;
    logic [2:0] done_bx;
    logic       busy;
    logic       overflow;

    modport master (
        output start, BX, number_in_proj1in, number_in_proj2in, number_in_proj3in,
        input  read_add_proj1in, read_add_proj2in, read_add_proj3in,
        input  sel, index, valid_data, bx_out, done, done_bx, busy, overflow
    );

    modport slave (
        input  start, BX, number_in_proj1in, number_in_proj2in, number_in_proj3in,
        output read_add_proj1in, read_add_proj2in, read_add_proj3in,
        output sel, index, valid_data, bx_out, done, done_bx, busy, overflow
    );
endinterface

// File: rtl/proj_read_scheduler.sv
// Round-robin read scheduler over three projection memories: issues at most one read per
// cycle per BX, tags returning data with its BX and reports drain completion of the prior BX.
module proj_read_scheduler #(
    parameter logic [6:0] MAX_READS   = 7'd100,
    parameter int         MEM_LATENCY = 2
) (
    input logic                  clk,
    input logic                  reset,
    proj_read_scheduler_if.slave bus
);
    localparam int LAST = MEM_LATENCY - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

    state_t     r_state, w_state_next;

    logic [5:0] w_num  [3];
    logic [5:0] w_base [3];
    logic [2:0] w_pend;
    logic [1:0] w_order [3];
    logic       w_exhaust, w_active, w_grant_v;
    logic [1:0] w_grant_src;
    logic [5:0] w_grant_addr;
    logic [2:0] w_tag;

    logic [5:0] r_cnt  [3];
    logic [5:0] r_radd [3];
    logic [6:0] r_issued;
    logic [1:0] r_last;
    logic [2:0] r_bx;
    logic       r_overflow, r_seen;

    logic       r_iss_v;
    logic [1:0] r_iss_sel;
    logic [5:0] r_iss_idx;
    logic [2:0] r_iss_bx;

    logic       r_pv   [MEM_LATENCY];
    logic [1:0] r_psel [MEM_LATENCY];
    logic [5:0] r_pidx [MEM_LATENCY];
    logic [2:0] r_pbx  [MEM_LATENCY];
    logic       r_dv   [MEM_LATENCY];
    logic [2:0] r_dbx  [MEM_LATENCY];

    logic [1:0] r_hold_sel;
    logic [5:0] r_hold_idx;
    logic [2:0] r_hold_bx, r_hold_dbx;

    function automatic logic [1:0] rr_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign w_num[0] = bus.number_in_proj1in;
    assign w_num[1] = bus.number_in_proj2in;
    assign w_num[2] = bus.number_in_proj3in;

    // On a start cycle the counters are treated as already cleared, so the first read of the new BX
    // is issued in that same cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pend
            assign w_base[gi] = bus.start ? 6'd0 : r_cnt[gi];
            assign w_pend[gi] = w_base[gi] < w_num[gi];
        end
    endgenerate

    assign w_exhaust = (r_state == RUN) && (r_issued >= MAX_READS);
    assign w_active  = bus.start || ((r_state == RUN) && !w_exhaust);
    assign w_tag     = bus.start ? bus.BX : r_bx;

    always_comb begin : arbiter
        w_order[0]   = rr_next(r_last);
        w_order[1]   = rr_next(w_order[0]);
        w_order[2]   = r_last;
        w_grant_v    = 1'b0;
        w_grant_src  = 2'd0;
        w_grant_addr = 6'd0;
        for (int j = 2; j >= 0; j--) begin
            if (w_active && w_pend[w_order[j]]) begin
                w_grant_v    = 1'b1;
                w_grant_src  = w_order[j];
                w_grant_addr = w_base[w_order[j]];
            end
        end
    end

    always_comb begin : fsm_next
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN:         if (w_exhaust) w_state_next = STALL;
                IDLE, STALL: w_state_next = r_state;
                default:     w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin : control
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 2'd2;
            r_issued   <= 7'd0;
            r_bx       <= 3'd0;
            r_overflow <= 1'b0;
            r_seen     <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_cnt[k]  <= 6'd0;
                r_radd[k] <= 6'd0;
            end
            r_iss_v   <= 1'b0;
            r_iss_sel <= 2'd0;
            r_iss_idx <= 6'd0;
            r_iss_bx  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            if (bus.start) begin
                r_bx       <= bus.BX;
                r_overflow <= 1'b0;
                r_seen     <= 1'b1;
            end else if (w_exhaust) begin
                r_overflow <= 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (w_grant_v && (w_grant_src == 2'(k))) begin
                    r_cnt[k]  <= w_base[k] + 6'd1;
                    r_radd[k] <= w_base[k];
                end else if (bus.start) begin
                    r_cnt[k] <= 6'd0;
                end
            end
            r_issued <= (bus.start ? 7'd0 : r_issued) + {6'd0, w_grant_v};
            if (w_grant_v) r_last <= w_grant_src;
            r_iss_v   <= w_grant_v;
            r_iss_sel <= w_grant_src;
            r_iss_idx <= w_grant_addr;
            r_iss_bx  <= w_tag;
        end
    end

    // Issue record trails the registered address by MEM_LATENCY cycles; done trails start the same way.
    always_ff @(posedge clk) begin : pipes
        if (!reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pv[i]   <= 1'b0;
                r_psel[i] <= 2'd0;
                r_pidx[i] <= 6'd0;
                r_pbx[i]  <= 3'd0;
                r_dv[i]   <= 1'b0;
                r_dbx[i]  <= 3'd0;
            end
            r_hold_sel <= 2'd0;
            r_hold_idx <= 6'd0;
            r_hold_bx  <= 3'd0;
            r_hold_dbx <= 3'd0;
        end else begin
            r_pv[0]   <= r_iss_v;
            r_psel[0] <= r_iss_sel;
            r_pidx[0] <= r_iss_idx;
            r_pbx[0]  <= r_iss_bx;
            r_dv[0]   <= bus.start && r_seen;
            r_dbx[0]  <= r_bx;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_psel[i] <= r_psel[i-1];
                r_pidx[i] <= r_pidx[i-1];
                r_pbx[i]  <= r_pbx[i-1];
                r_dv[i]   <= r_dv[i-1];
                r_dbx[i]  <= r_dbx[i-1];
            end
            if (r_pv[LAST]) begin
                r_hold_sel <= r_psel[LAST];
                r_hold_idx <= r_pidx[LAST];
                r_hold_bx  <= r_pbx[LAST];
            end
            if (r_dv[LAST]) r_hold_dbx <= r_dbx[LAST];
        end
    end

    assign bus.read_add_proj1in = r_radd[0];
    assign bus.read_add_proj2in = r_radd[1];
    assign bus.read_add_proj3in = r_radd[2];
    assign bus.valid_data       = r_pv[LAST];
    assign bus.sel              = r_pv[LAST] ? r_psel[LAST] : r_hold_sel;
    assign bus.index            = r_pv[LAST] ? r_pidx[LAST] : r_hold_idx;
    assign bus.bx_out           = r_pv[LAST] ? r_pbx[LAST]  : r_hold_bx;
    assign bus.done             = r_dv[LAST];
    assign bus.done_bx          = r_dv[LAST] ? r_dbx[LAST]  : r_hold_dbx;
    assign bus.busy             = (r_state == RUN);
    assign bus.overflow         = r_overflow;
endmodule

// File: tb/tb_proj_read_scheduler.sv
// Directed bench for proj_read_scheduler (MAX_READS=4, MEM_LATENCY=2): a schedule-based model
// checked every cycle, plus literal expectations for each scenario.
module tb_proj_read_scheduler;
    localparam int L    = 2;
    localparam int MAXR = 4;
    localparam int NS   = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    proj_read_scheduler_if bus ();

    proj_read_scheduler #(.MAX_READS(7'd4), .MEM_LATENCY(L)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Model: which cycle each word/done must appear in, derived from the scheduling rules.
    int m_mode;  // 0 idle, 1 run, 2 stall
    int m_cnt [3];
    int m_radd [3];
    int m_issued, m_last, m_bx;
    bit m_ovf, m_seen;
    bit s_v [NS];
    int s_sel [NS];
    int s_idx [NS];
    int s_bx  [NS];
    bit s_d [NS];
    int s_dbx [NS];
    bit e_v, e_done, e_busy, e_ovf;
    int e_sel, e_idx, e_bxo, e_dbx;

    always @(posedge clk) begin : model
        int nums [3];
        int base [3];
        int c, g, tag;
        bit act, gv;
        cyc++;
        nums[0] = int'(bus.number_in_proj1in);
        nums[1] = int'(bus.number_in_proj2in);
        nums[2] = int'(bus.number_in_proj3in);
        if (!rst_n) begin
            m_mode = 0; m_issued = 0; m_last = 2; m_bx = 0; m_ovf = 0; m_seen = 0;
            for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_radd[k] = 0; end
            for (int i = cyc; i < cyc + 8 && i < NS; i++) begin s_v[i] = 0; s_d[i] = 0; end
            e_sel = 0; e_idx = 0; e_bxo = 0; e_dbx = 0;
        end else begin
            gv = 0; g = 0;
            act = bus.start || (m_mode == 1 && m_issued < MAXR);
            for (int k = 0; k < 3; k++) base[k] = bus.start ? 0 : m_cnt[k];
            if (act) begin
                for (int j = 1; j <= 3; j++) begin
                    c = (m_last + j) % 3;
                    if (!gv && base[c] < nums[c]) begin gv = 1; g = c; end
                end
            end
            tag = bus.start ? int'(bus.BX) : m_bx;
            if (bus.start && m_seen) begin s_d[cyc - 1 + L] = 1; s_dbx[cyc - 1 + L] = m_bx; end
            if (bus.start) begin
                m_mode = 1; m_bx = int'(bus.BX); m_ovf = 0; m_seen = 1; m_issued = 0;
                for (int k = 0; k < 3; k++) m_cnt[k] = 0;
            end else if (m_mode == 1 && m_issued >= MAXR) begin
                m_mode = 2; m_ovf = 1;
            end
            if (gv) begin
                m_radd[g] = base[g];
                m_cnt[g]  = base[g] + 1;
                m_issued++;
                m_last = g;
                s_v[cyc + L] = 1; s_sel[cyc + L] = g; s_idx[cyc + L] = base[g]; s_bx[cyc + L] = tag;
            end
        end
        e_v = s_v[cyc];
        if (e_v) begin e_sel = s_sel[cyc]; e_idx = s_idx[cyc]; e_bxo = s_bx[cyc]; end
        e_done = s_d[cyc];
        if (e_done) e_dbx = s_dbx[cyc];
        e_busy = (m_mode == 1);
        e_ovf  = m_ovf;
    end

    always @(negedge clk) begin : compare
        if (cyc > 0) begin
            chk("valid_data", bus.valid_data, e_v);
            chk("sel", bus.sel, e_sel);
            chk("index", bus.index, e_idx);
            chk("bx_out", bus.bx_out, e_bxo);
            chk("done", bus.done, e_done);
            chk("done_bx", bus.done_bx, e_dbx);
            chk("busy", bus.busy, e_busy);
            chk("overflow", bus.overflow, e_ovf);
            chk("read_add_proj1in", bus.read_add_proj1in, m_radd[0]);
            chk("read_add_proj2in", bus.read_add_proj2in, m_radd[1]);
            chk("read_add_proj3in", bus.read_add_proj3in, m_radd[2]);
        end
    end

    // Captured words are encoded sel*1000 + index*10 + bx.
    int cap [$];
    int capcyc [$];
    int dq [$];
    int dqcyc [$];

    always @(negedge clk) begin : capture
        if (bus.valid_data === 1'b1) begin
            cap.push_back(int'(bus.sel) * 1000 + int'(bus.index) * 10 + int'(bus.bx_out));
            capcyc.push_back(cyc);
            $display("word cyc=%0d sel=%0d index=%0d bx=%0d", cyc, bus.sel, bus.index, bus.bx_out);
        end
        if (bus.done === 1'b1) begin
            dq.push_back(int'(bus.done_bx));
            dqcyc.push_back(cyc);
            $display("done cyc=%0d done_bx=%0d", cyc, bus.done_bx);
        end
    end

    function automatic int qget(input int q [$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] bx);
        bus.BX    = bx;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic set_nums(input int a, input int b, input int c);
        bus.number_in_proj1in = 6'(a);
        bus.number_in_proj2in = 6'(b);
        bus.number_in_proj3in = 6'(c);
    endtask

    initial begin : stim
        int b, db, s;
        rst_n = 1'b0; bus.start = 1'b0; bus.BX = 3'd0;
        set_nums(0, 0, 0);
        tick(3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid_data, 0);
        chk("rst_radd1", bus.read_add_proj1in, 0);
        rst_n = 1'b1;

        // Scenario 1: numbers 2,1,0 -> src0@0, src1@0, src0@1, tagged 3
        set_nums(2, 1, 0);
        b = cap.size(); s = cyc;
        pulse(3'd3);
        tick(8);
        chk("s1_count", cap.size() - b, 3);
        chk("s1_w0", qget(cap, b), 3);
        chk("s1_w1", qget(cap, b + 1), 1003);
        chk("s1_w2", qget(cap, b + 2), 13);
        chk("s1_first_cyc", qget(capcyc, b), s + 3);
        chk("s1_span", qget(capcyc, b + 2) - qget(capcyc, b), 2);

        // Scenario 2: empty sources, then source 1 fills one entry
        set_nums(0, 0, 0);
        b = cap.size(); db = dq.size(); s = cyc;
        pulse(3'd1);
        tick(4);
        chk("s2_busy", bus.busy, 1);
        chk("s2_none", cap.size() - b, 0);
        chk("s2_done_bx", qget(dq, db), 3);
        chk("s2_done_cyc", qget(dqcyc, db), s + 2);
        bus.number_in_proj2in = 6'd1;
        tick(6);
        chk("s2_count", cap.size() - b, 1);
        chk("s2_w0", qget(cap, b), 1001);

        // Scenario 3: budget of 4 reads
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        set_nums(3, 3, 3);
        b = cap.size(); db = dq.size();
        pulse(3'd2);
        tick(10);
        chk("s3_count", cap.size() - b, 4);
        chk("s3_w0", qget(cap, b), 2);
        chk("s3_w1", qget(cap, b + 1), 1002);
        chk("s3_w2", qget(cap, b + 2), 2002);
        chk("s3_w3", qget(cap, b + 3), 12);
        chk("s3_overflow", bus.overflow, 1);
        chk("s3_busy", bus.busy, 0);
        chk("s3_no_done", dq.size() - db, 0);

        // Scenario 4: new BX while two reads of BX 5 are in flight
        set_nums(10, 10, 10);
        b = cap.size(); db = dq.size(); s = cyc;
        pulse(3'd5);
        tick(1);
        pulse(3'd6);
        tick(8);
        chk("s4_count", cap.size() - b, 6);
        chk("s4_w0", qget(cap, b), 1005);
        chk("s4_w1", qget(cap, b + 1), 2005);
        chk("s4_w2", qget(cap, b + 2), 6);
        chk("s4_done0_bx", qget(dq, db), 2);
        chk("s4_done0_cyc", qget(dqcyc, db), s + 2);
        chk("s4_done1_bx", qget(dq, db + 1), 5);
        chk("s4_done1_cyc", qget(dqcyc, db + 1), s + 4);

        // Scenario 5: reset with a read in flight
        pulse(3'd7);
        rst_n = 1'b0;
        tick(1);
        chk("s5_valid", bus.valid_data, 0);
        chk("s5_busy", bus.busy, 0);
        chk("s5_overflow", bus.overflow, 0);
        chk("s5_done", bus.done, 0);
        chk("s5_sel", bus.sel, 0);
        chk("s5_index", bus.index, 0);
        chk("s5_bx_out", bus.bx_out, 0);
        chk("s5_done_bx", bus.done_bx, 0);
        chk("s5_radd2", bus.read_add_proj2in, 0);
        rst_n = 1'b1;
        b = cap.size(); db = dq.size();
        tick(5);
        chk("s5_no_words", cap.size() - b, 0);
        chk("s5_no_done", dq.size() - db, 0);
        set_nums(1, 0, 0);
        pulse(3'd1);
        tick(6);
        chk("s5_first_start_no_done", dq.size() - db, 0);
        chk("s5_count", cap.size() - b, 1);
        chk("s5_w0", qget(cap, b), 1);

        // Scenario 6: start in the budget-exhaustion cycle
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        set_nums(5, 5, 5);
        b = cap.size(); db = dq.size(); s = cyc;
        pulse(3'd4);
        tick(3);
        chk("s6_busy_pre", bus.busy, 1);
        pulse(3'd6);
        chk("s6_busy", bus.busy, 1);
        chk("s6_overflow", bus.overflow, 0);
        tick(10);
        chk("s6_count", cap.size() - b, 8);
        chk("s6_w3", qget(cap, b + 3), 14);
        chk("s6_w4", qget(cap, b + 4), 1006);
        chk("s6_done_bx", qget(dq, db), 4);
        chk("s6_done_cyc", qget(dqcyc, db), s + 6);
        chk("s6_overflow_end", bus.overflow, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
